// File: rtl/uart_word_pkg.sv
// Shared types and helpers for the UART word receiver (cycle_uart_in and uart_rx_byte).
package uart_word_pkg;

  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_WORD_PART = 8;
  localparam int N_PARTS       = DEF_WORD_SIZE / DEF_WORD_PART;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop rx synchroniser, bit-timer (down-counter) and frame FSM.
//   state | meaning
//   IDLE  | line idle, waiting for a low level
//   START | timing to mid start bit; a high level there is a glitch
//   DATA  | sampling WORD_PART data bits LSB first, one per bit period
//   STOP  | sampling stop bit; after a bad stop, holds until the line is high
module uart_rx_byte
  import uart_word_pkg::*;
#(
  parameter int WORD_PART    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [WORD_PART-1:0] rx_byte,
  output logic                 byte_valid,
  output logic                 frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = (WORD_PART > 1) ? $clog2(WORD_PART) : 1;
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WORD_PART-1:0] sr_q, sr_d;
  logic rx_meta_q, rx_sync_q;
  logic bad_q, bad_d;
  logic byte_valid_q, byte_valid_d;
  logic frame_err_q, frame_err_d;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_q        <= '0;
      sr_q         <= '0;
      bad_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_q        <= bit_d;
      sr_q         <= sr_d;
      bad_q        <= bad_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = (timer_q == '0) ? '0 : timer_q - TW'(1);
    bit_d        = bit_q;
    sr_d         = sr_q;
    bad_d        = bad_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = START;
          timer_d = HALF_BIT;
        end
      end
      START: begin
        if (timer_q == '0) begin
          if (!rx_sync_q) begin
            state_d = DATA;
            timer_d = FULL_BIT;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          sr_d    = {rx_sync_q, sr_q[WORD_PART-1:1]};
          timer_d = FULL_BIT;
          if (bit_q == BW'(WORD_PART - 1)) state_d = STOP;
          else bit_d = bit_q + BW'(1);
        end
      end
      STOP: begin
        if (bad_q) begin
          if (rx_sync_q) begin
            bad_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (timer_q == '0) begin
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            bad_d       = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte    = sr_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/cycle_uart_in.sv
// UART word receiver: joins bytes LSB-first into words and buffers them in a FWFT FIFO.
// Optional byte-gap timeout that drops stale partial words: WORD_TIMEOUT_EN.
module cycle_uart_in
  import uart_word_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int WORD_PART = 8,
  parameter int MEM_SIZE  = 64,
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 200_000_000
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 frame_err
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int N   = WORD_SIZE / WORD_PART;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int AW  = $clog2(MEM_SIZE);

  logic [WORD_PART-1:0] rx_byte;
  logic byte_valid, rx_frame_err;

  uart_rx_byte #(.WORD_PART(WORD_PART), .CLKS_PER_BIT(CPB)) u_rx (
    .clock      (clock),
    .rstn       (rstn),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (rx_frame_err)
  );

  logic [CW-1:0] cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] part_q, part_d, push_word;
  logic push_req, do_push, do_pop;
  logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic valid_q, valid_d, full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;

`ifdef WORD_TIMEOUT_EN
  localparam int GAP = 2 * (WORD_PART + 2) * CPB;
  localparam int GW  = $clog2(GAP + 1);
  logic [GW-1:0] gap_q, gap_d;
  logic to_err_q, to_err_d;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      gap_q    <= GW'(GAP - 1);
      to_err_q <= 1'b0;
    end else begin
      gap_q    <= gap_d;
      to_err_q <= to_err_d;
    end
  end

  assign frame_err = rx_frame_err | to_err_q;
`else
  assign frame_err = rx_frame_err;
`endif

  always_comb begin
    part_d   = part_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    if (byte_valid) begin
      for (int k = 0; k < N; k++)
        if (cnt_q == CW'(k)) part_d[k*WORD_PART +: WORD_PART] = rx_byte;
      if (cnt_q == CW'(N - 1)) begin
        push_req = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    push_word = part_d;
`ifdef WORD_TIMEOUT_EN
    to_err_d = 1'b0;
    if (byte_valid || cnt_q == '0) gap_d = GW'(GAP - 1);
    else gap_d = (gap_q == '0) ? '0 : gap_q - GW'(1);
    // Gap expired with a partial word: restart alignment from byte 0.
    if (!byte_valid && cnt_q != '0 && gap_q == '0) begin
      cnt_d    = '0;
      to_err_d = 1'b1;
    end
`endif
  end

  always_comb begin
    do_pop  = valid_q && ready_in;
    do_push = push_req && (!full_q || do_pop);
    ovf_d   = ovf_q | (push_req && full_q && !do_pop);
    rd_d    = rd_q + AW'(do_pop);
    wr_d    = wr_q + AW'(do_push);
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    // Head after this edge is the incoming word when it lands at the new read slot.
    data_out_d = data_out_q;
    if (count_d != '0) begin
      if (do_push && wr_q == rd_d) data_out_d = push_word;
      else data_out_d = mem_q[rd_d];
    end
    valid_d = (count_d != '0);
    full_d  = (count_d == (AW+1)'(MEM_SIZE));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_word;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      part_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      part_q     <= part_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cycle_uart_in.sv
// Directed bench for cycle_uart_in at 16 clocks per bit; the timeout case runs only with WORD_TIMEOUT_EN.
module tb_cycle_uart_in;

  localparam int CPB = 16;

  logic clock = 1'b0;
  logic rstn = 1'b0;
  logic rx = 1'b1;
  logic ready_in = 1'b1;
  logic [31:0] data_out;
  logic valid_out, full, empty, overflow, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int rise_cyc = -1;
  int fe_cnt = 0;
  logic v_prev = 1'b0;
  logic [31:0] rxq[$];
  int fe_base;

  cycle_uart_in #(
    .WORD_SIZE(32), .WORD_PART(8), .MEM_SIZE(64),
    .BAUD_RATE(100_000), .CLK_FREQ(1_600_000)
  ) dut (
    .clock(clock), .rstn(rstn), .rx(rx),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .full(full), .empty(empty), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid_out && ready_in) rxq.push_back(data_out);
    if (frame_err) fe_cnt++;
    if (valid_out && !v_prev) rise_cyc = cyc;
    v_prev = valid_out;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_bit();
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    last_start = cyc;
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bit();
    end
    rx = stop_bit;
    wait_bit();
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  function automatic logic [31:0] ovf_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hC3, ~b, 8'h5A, b};
  endfunction

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    rstn = 1'b1;
    idle(10);

    // basic word and latency
    rxq.delete();
    fe_base = fe_cnt;
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    idle(20);
    chk("w1_count", rxq.size(), 1);
    chk("w1_data", (rxq.size() > 0) ? rxq[0] : 32'hx, 32'h11223344);
    chk("w1_latency", rise_cyc - last_start, 156);
    chk("w1_frame_err", fe_cnt - fe_base, 0);

    // start-bit glitch
    rxq.delete();
    rx = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    idle(40);
    chk("glitch_no_word", rxq.size(), 0);
    chk("glitch_no_ferr", fe_cnt - fe_base, 0);
    send_word(32'hDDCCBBAA);
    idle(20);
    chk("glitch_count", rxq.size(), 1);
    chk("glitch_data", (rxq.size() > 0) ? rxq[0] : 32'hx, 32'hDDCCBBAA);

    // bad stop bit
    rxq.delete();
    fe_base = fe_cnt;
    send_byte(8'hEE, 1'b0);
    idle(20);
    chk("badstop_ferr", fe_cnt - fe_base, 1);
    send_word(32'h04030201);
    idle(20);
    chk("badstop_count", rxq.size(), 1);
    chk("badstop_data", (rxq.size() > 0) ? rxq[0] : 32'hx, 32'h04030201);
    chk("badstop_ferr_once", fe_cnt - fe_base, 1);

    // reset mid-word
    rxq.delete();
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_valid", valid_out, 0);
    repeat (3) @(posedge clock);
    #1;
    rstn = 1'b1;
    idle(10);
    send_word(32'h40302010);
    idle(20);
    chk("rst_mid_count", rxq.size(), 1);
    chk("rst_mid_data", (rxq.size() > 0) ? rxq[0] : 32'hx, 32'h40302010);

`ifdef WORD_TIMEOUT_EN
    rxq.delete();
    fe_base = fe_cnt;
    send_byte(8'hF1, 1'b1);
    send_byte(8'hF2, 1'b1);
    idle(320);
    chk("to_ferr", fe_cnt - fe_base, 1);
    send_word(32'h08070605);
    idle(20);
    chk("to_count", rxq.size(), 1);
    chk("to_data", (rxq.size() > 0) ? rxq[0] : 32'hx, 32'h08070605);
    chk("to_ferr_once", fe_cnt - fe_base, 1);
`endif

    // fill, overflow, drain
    rxq.delete();
    ready_in = 1'b0;
    for (int i = 1; i <= 63; i++) send_word(ovf_word(i));
    idle(4);
    chk("fill63_full", full, 0);
    chk("fill63_empty", empty, 0);
    send_word(ovf_word(64));
    idle(4);
    chk("fill64_full", full, 1);
    chk("fill64_overflow", overflow, 0);
    chk("fill64_head", data_out, ovf_word(1));
    send_word(ovf_word(65));
    idle(4);
    chk("fill65_overflow", overflow, 1);
    chk("fill65_full", full, 1);
    chk("fill65_head_stable", data_out, ovf_word(1));
    chk("fill65_valid", valid_out, 1);
    ready_in = 1'b1;
    idle(100);
    chk("drain_count", rxq.size(), 64);
    for (int i = 0; i < 64; i++)
      chk($sformatf("drain_%0d", i + 1), (i < rxq.size()) ? rxq[i] : 32'hx, ovf_word(i + 1));
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);
    chk("drain_valid", valid_out, 0);
    chk("drain_overflow_sticky", overflow, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
